// File: rtl/result_drain_pkg.sv
// Shared sizing constants for the result drain slice: row width, row-index width
// and output beat width.
package result_drain_pkg;

  localparam int WORD_SIZE     = 256;
  localparam int ROW_SIZE      = 5;
  localparam int OUT_BEAT_SIZE = 32;

  localparam int ROW_DEPTH     = 1 << ROW_SIZE;

endpackage

// File: rtl/drain_row_buffer.sv
// Row storage for one captured burst: a flop array with one write port and an
// asynchronous read port. Contents are deliberately not reset.
module drain_row_buffer #(
  parameter int WORD_W = 256,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/result_drain.sv
// Captures an unstallable burst of wide rows and replays it as narrow beats on a
// valid/ready stream. Define RESULT_DRAIN_MSB_FIRST_EN to emit the top lane first.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int WORD_W = WORD_SIZE,
  parameter int OUT_W  = OUT_BEAT_SIZE,
  parameter int DEPTH  = ROW_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  localparam int LANES = WORD_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [AW:0]   FULL_ROWS = (AW+1)'(DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [AW:0]       wr_row;
  logic [AW:0]       rd_row;
  logic [LW-1:0]     rd_lane;
  logic [LW-1:0]     lane_sel;
  logic              wr_en;
  logic              row_full;
  logic              beat_fire;
  logic              beat_last;
  logic [WORD_W-1:0] rd_data;

  drain_row_buffer #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_rows (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_row[AW-1:0]),
    .wr_data (in_data),
    .rd_idx  (rd_row[AW-1:0]),
    .rd_data (rd_data)
  );

  assign row_full  = (wr_row == FULL_ROWS);
  assign beat_last = (rd_row == wr_row - 1'b1) && (rd_lane == LAST_LANE);
  assign beat_fire = out_valid && out_ready;

  // rd_lane counts beats within a row; lane_sel picks which slice that beat carries.
`ifdef RESULT_DRAIN_MSB_FIRST_EN
  assign lane_sel = LAST_LANE - rd_lane;
`else
  assign lane_sel = rd_lane;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = CAPTURE;
      CAPTURE: if (!in_valid) state_next = DRAIN;
      DRAIN:   if (beat_fire && beat_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      IDLE:    wr_en = in_valid;
      CAPTURE: begin
        busy  = 1'b1;
        wr_en = in_valid && !row_full;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = rd_data[lane_sel*OUT_W +: OUT_W];
        out_last  = beat_last;
      end
      default: ;
    endcase
  end

  // Row/lane counters and the sticky drop flag; overflow only clears when a new burst begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row   <= '0;
      rd_row   <= '0;
      rd_lane  <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            wr_row   <= (AW+1)'(1);
            overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            if (!row_full) wr_row <= wr_row + 1'b1;
            else           overflow <= 1'b1;
          end
        end
        DRAIN: begin
          if (in_valid) overflow <= 1'b1;
          if (beat_fire) begin
            if (beat_last) begin
              wr_row  <= '0;
              rd_row  <= '0;
              rd_lane <= '0;
            end else if (rd_lane == LAST_LANE) begin
              rd_lane <= '0;
              rd_row  <= rd_row + 1'b1;
            end else begin
              rd_lane <= rd_lane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: bursts of known rows, drained with and without
// backpressure, plus overflow, reset-abort and drop-during-drain cases.
module tb_result_drain;

  localparam int WORD_W = 256;
  localparam int OUT_W  = 32;
  localparam int LANES  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OUT_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              overflow;

  int assertions = 0;
  int failures   = 0;

  result_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lane_word(int r, int l);
    logic [7:0] rb, lb;
    rb = r[7:0];
    lb = l[7:0];
    return {rb, lb, ~rb, ~lb};
  endfunction

  function automatic logic [WORD_W-1:0] make_row(int r);
    logic [WORD_W-1:0] row;
    row = '0;
    for (int l = 0; l < LANES; l++) row[l*OUT_W +: OUT_W] = lane_word(r, l);
    return row;
  endfunction

  function automatic logic [31:0] beat_word(int r, int k);
`ifdef RESULT_DRAIN_MSB_FIRST_EN
    return lane_word(r, LANES - 1 - k);
`else
    return lane_word(r, k);
`endif
  endfunction

  task automatic applyStimulus(input int nrows);
    for (int i = 0; i < nrows; i++) begin
      in_valid = 1'b1;
      in_data  = make_row(i);
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    checkOutput("capture_busy", 32'(busy), 32'd1);
    checkOutput("capture_no_valid", 32'(out_valid), 32'd0);
    step();
  endtask

  task automatic drainCheck(input string name, input int nrows, input bit random_ready,
                            input int inject_at, input int stop_at);
    int  total;
    int  beat;
    int  cycles;
    bit  injected;
    total    = nrows * LANES;
    beat     = 0;
    cycles   = 0;
    injected = 1'b0;
    while (beat < total && beat != stop_at && cycles < 4000) begin
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beat == inject_at && !injected) begin
        in_valid = 1'b1;
        in_data  = {8{32'hDEAD_BEEF}};
        injected = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      checkOutput($sformatf("%s_valid_b%0d", name, beat), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s_data_b%0d", name, beat), out_data, beat_word(beat / LANES, beat % LANES));
      checkOutput($sformatf("%s_last_b%0d", name, beat), 32'(out_last), 32'(beat == total - 1));
      if (out_ready) beat++;
      cycles++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (stop_at < 0) begin
      checkOutput($sformatf("%s_beats", name), beat, total);
      checkOutput($sformatf("%s_idle_valid", name), 32'(out_valid), 32'd0);
      checkOutput($sformatf("%s_idle_busy", name), 32'(busy), 32'd0);
    end else begin
      checkOutput($sformatf("%s_reached_stop", name), beat, stop_at);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_data", out_data, 32'd0);
    checkOutput("reset_last", 32'(out_last), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    step();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    $display("[TB] full burst, no stall");
    applyStimulus(32);
    drainCheck("full", 32, 1'b0, -1, -1);
    checkOutput("full_overflow", 32'(overflow), 32'd0);

    $display("[TB] full burst, random backpressure");
    applyStimulus(32);
    drainCheck("bp", 32, 1'b1, -1, -1);

    $display("[TB] overflow burst of 34 rows");
    applyStimulus(34);
    drainCheck("ovf", 32, 1'b0, -1, -1);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    step();
    checkOutput("ovf_held", 32'(overflow), 32'd1);

    $display("[TB] short burst of 3 rows");
    applyStimulus(3);
    checkOutput("short_ovf_cleared", 32'(overflow), 32'd0);
    drainCheck("short", 3, 1'b0, -1, -1);

    $display("[TB] reset mid-drain");
    applyStimulus(33);
    drainCheck("rst", 32, 1'b0, -1, 100);
    checkOutput("rst_pre_ovf", 32'(overflow), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_async_data", out_data, 32'd0);
    checkOutput("rst_async_last", 32'(out_last), 32'd0);
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    checkOutput("rst_async_ovf", 32'(overflow), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(1);
    drainCheck("one", 1, 1'b0, -1, -1);
    checkOutput("one_overflow", 32'(overflow), 32'd0);

    $display("[TB] in_valid during drain");
    applyStimulus(2);
    drainCheck("inj", 2, 1'b0, 10, -1);
    checkOutput("inj_overflow", 32'(overflow), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Downstream neighbour of the TPU top wrapper. Captures the uninterruptible burst of 256-bit result rows that `top` emits on `out_valid`/`gbuff_out`.
- Buffers the whole burst locally, then serialises it as 32-bit beats on a valid/ready stream with a last marker.
- Absorbs the mismatch between the burst (no backpressure) and a narrow, stallable host/DMA link.

Parameters:
- WORD_W, 256, width of one captured row (matches `WORD_SIZE`).
- OUT_W, 32, width of one output beat; WORD_W must be an integer multiple.
- DEPTH, 32, rows stored per burst; power of two.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  row strobe from top `out_valid`
- in_data  in  WORD_W  row data from top `gbuff_out`
- out_valid  out  1  beat valid
- out_ready  in  1  beat accepted by consumer
- out_data  out  OUT_W  beat payload
- out_last  out  1  final beat of the burst
- busy  out  1  high in CAPTURE or DRAIN; host must not start a new TPU job while set
- overflow  out  1  sticky: one or more rows were dropped

Behaviour:
- LANES = WORD_W/OUT_W (8). Counters: wr_row (log2(DEPTH)+1 bits), rd_row, rd_lane.
- Reset values: state IDLE, counters 0, out_valid 0, out_data 0, out_last 0, busy 0, overflow 0. The row array is not reset.
- IDLE:
  - If in_valid is high, write in_data to row 0, set wr_row=1, clear overflow, and go to CAPTURE.
  - If in_valid is low, stay in IDLE.
- CAPTURE:
  - Each in_valid cycle with wr_row<DEPTH writes row[wr_row] and increments wr_row.
  - Each in_valid cycle with wr_row==DEPTH drops the row and sets overflow.
  - The first cycle with in_valid low goes to DRAIN at the next edge. The burst end is detected by in_valid falling, not by a fixed count.
- DRAIN:
  - out_valid=1 combinationally from state, so the first beat is valid in the cycle after the first in_valid-low cycle.
  - out_data = row[rd_row][rd_lane*OUT_W +: OUT_W]; lane 0 = bits [31:0].
  - out_last = (rd_row==wr_row-1) && (rd_lane==LANES-1).
  - On out_valid&&out_ready: advance rd_lane; on wrap, advance rd_row. The handshake on the last beat returns to IDLE and clears all counters.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - in_valid during DRAIN: the row is dropped and overflow is set; the drain continues unaffected.
- Outside DRAIN: out_valid=0, out_data=0, out_last=0.
- Total beats = wr_row*LANES; a full burst is 256 beats.
- Boundaries:
  - A single-row burst is legal: 8 beats, last on beat 7.
  - Async reset mid-CAPTURE or mid-DRAIN aborts immediately to IDLE; buffered data is discarded and overflow is cleared.
  - Consumer stalled indefinitely: the block holds its state; there is no timeout.

Optional Feature:
- Macro: RESULT_DRAIN_MSB_FIRST_EN.
- Defined: lanes are emitted from highest to lowest, so lane LANES-1 = bits [255:224] goes first. out_last is then asserted on lane 0 of the final row.
- Undefined: LSB lane first, as above. Row order is unchanged in both cases.

Decomposition:
- Shared define file supplies WORD_SIZE (256) and ROW_SIZE (5) for DEPTH/index widths; add OUT_BEAT_SIZE (32) there.
- State encodings (IDLE/CAPTURE/DRAIN) stay local.
- One natural sub-module, `drain_row_buffer`: DEPTH×WORD_W flop array with one write port (wr_en, wr_idx, wr_data) and a combinational read port (rd_idx → rd_data).
- The FSM, counters and lane mux remain in result_drain.

Test Plan:
- Full burst, no stall: 32 rows, row r = {8{r[7:0],lane}} pattern, out_ready=1. Expect out_valid rising 1 cycle after in_valid falls, 256 beats in consecutive cycles, beat 8r+l = pattern(r,l), out_last only on beat 255, busy low the cycle after, overflow=0.
- Random backpressure: same burst with out_ready 50% random. Expect an identical beat sequence and out_data/out_last stable across every stall cycle.
- Short burst: 3 rows, then in_valid low. Expect 24 beats, out_last on beat 23, return to IDLE.
- Overflow: 34 consecutive in_valid rows. Expect rows 0–31 drained (256 beats), overflow=1 and held until the next burst start, then cleared.
- Reset mid-drain: assert rst_n=0 at beat 100 for 2 cycles. Expect outputs 0 asynchronously. A subsequent 1-row burst drains 8 correct beats with overflow=0.
- In_valid during DRAIN: pulse in_valid at beat 10 of a 2-row drain. Expect overflow=1 and 16 beats with unchanged data.
